// File: rtl/led_fade_driver.sv
// -----------------------------------------------------------------------------
// led_fade_driver
//   Turns the hard on/off LED pattern from the Blink generator into soft fades.
//   Each of the 8 channels has a target: the global brightness when its
//   pattern bit is set, 0 otherwise. A brightness level walks toward that
//   target by one step per prescaler tick, and an 8-bit PWM (period 255
//   cycles) drives the pin from the level.
//
// Parameters
//   CLK_FREQ      system clock frequency in Hz
//   FADE_STEP_HZ  level step rate; STEP_DIV = CLK_FREQ / FADE_STEP_HZ (>= 1)
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         synchronous reset, active-high
//   leds_in     [7:0] pattern from Blink; bit i = 1 requests channel i on
//   brightness  [7:0] global on-level, sampled every cycle
//   enable      0 forces all channels dark on the next edge
//   leds_out    [7:0] registered PWM drive to the LED pins
//   busy        1 while any channel level differs from its target (comb.)
// -----------------------------------------------------------------------------
module led_fade_driver #(
  parameter int CLK_FREQ     = 25_000_000,
  parameter int FADE_STEP_HZ = 1_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] leds_in,
  input  logic [7:0] brightness,
  input  logic       enable,
  output logic [7:0] leds_out,
  output logic       busy
);

  localparam int STEP_DIV = CLK_FREQ / FADE_STEP_HZ;
  localparam int PW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(STEP_DIV - 1);
  localparam logic [7:0]    PWM_MAX   = 8'd254;

  if (STEP_DIV < 1) begin : g_bad_step_div
    $error("led_fade_driver: CLK_FREQ / FADE_STEP_HZ must be >= 1");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic [7:0]    level_q [8];
  logic [7:0]    level_d [8];
  logic [7:0]    target  [8];
  logic [7:0]    leds_out_q, leds_out_d;
  logic [7:0]    off_target;
  logic          tick;

  // Next-state logic.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    tick       = enable && (presc_q == PRESC_MAX);
    presc_d    = '0;
    pwm_cnt_d  = (pwm_cnt_q == PWM_MAX) ? 8'd0 : pwm_cnt_q + 8'd1;
    leds_out_d = '0;
    off_target = '0;

    // The prescaler only runs while enabled, so a re-enable always waits a
    // full STEP_DIV cycles before the first step.
    if (enable && !tick) begin
      presc_d = presc_q + 1'b1;
    end

    for (int i = 0; i < 8; i++) begin
      target[i]     = leds_in[i] ? brightness : 8'd0;
      off_target[i] = (level_q[i] != target[i]);
      level_d[i]    = level_q[i];

      // Disable wins over a coincident tick. Stepping by one and stopping on
      // equality means a level can never overshoot or wrap, and a new target
      // simply redirects the walk from wherever the level currently is.
      if (!enable) begin
        level_d[i] = 8'd0;
      end else if (tick) begin
        if (level_q[i] < target[i]) begin
          level_d[i] = level_q[i] + 8'd1;
        end else if (level_q[i] > target[i]) begin
          level_d[i] = level_q[i] - 8'd1;
        end
      end

      // Compare uses the pre-update level; pwm_cnt never reaches 255, so
      // level 255 is solidly on and level 0 solidly off.
      leds_out_d[i] = enable && (pwm_cnt_q < level_q[i]);
    end
  end

  assign busy     = enable && (|off_target);
  assign leds_out = leds_out_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before this edge.
  // The eight level registers are ordinary flops, so they are reset like any
  // other state; a reset mid-ramp leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      pwm_cnt_q  <= '0;
      leds_out_q <= '0;
      for (int i = 0; i < 8; i++) begin
        level_q[i] <= 8'd0;
      end
    end else begin
      presc_q    <= presc_d;
      pwm_cnt_q  <= pwm_cnt_d;
      leds_out_q <= leds_out_d;
      for (int i = 0; i < 8; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// -----------------------------------------------------------------------------
// tb_led_fade_driver
//   Self-checking bench for led_fade_driver with CLK_FREQ=1000 and
//   FADE_STEP_HZ=100 (STEP_DIV=10). Steady-state duty cycles come from a
//   vector table; ramps, disable and reset corners are hand-written sequences
//   started from a reset so the prescaler phase is known.
// -----------------------------------------------------------------------------
module tb_led_fade_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] leds_in;
  logic [7:0] brightness;
  logic       enable;
  logic [7:0] leds_out;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int hi_cnt [8];
  int phase_diff;
  int bad;

  typedef struct {
    logic [7:0] leds;
    logic [7:0] bright;
    logic       en;
    logic [7:0] mask;    // channels expected to be lit
    int         hi;      // high cycles per 255-cycle period on lit channels
  } vec_t;

  vec_t vecs [6];

  led_fade_driver #(
    .CLK_FREQ     (1000),
    .FADE_STEP_HZ (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .leds_in    (leds_in),
    .brightness (brightness),
    .enable     (enable),
    .leds_out   (leds_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Advance n clock edges, then settle 1 time unit past the last edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Count high cycles per channel over one full PWM period.
  task automatic measure();
    for (int b = 0; b < 8; b++) hi_cnt[b] = 0;
    phase_diff = 0;
    for (int c = 0; c < 255; c++) begin
      cyc(1);
      for (int b = 0; b < 8; b++) hi_cnt[b] += int'(leds_out[b]);
      if (leds_out[0] != leds_out[7]) phase_diff++;
    end
  endtask

  // Reset for two edges, then release with the given drive.
  task automatic do_reset(input logic [7:0] l, input logic [7:0] br);
    rst = 1'b1; enable = 1'b1; leds_in = l; brightness = br;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h81, 8'd64,  1'b1, 8'h81, 64};
    vecs[1] = '{8'hFF, 8'd255, 1'b1, 8'hFF, 255};
    vecs[2] = '{8'h5A, 8'd1,   1'b1, 8'h5A, 1};
    vecs[3] = '{8'hA5, 8'd0,   1'b1, 8'h00, 0};
    vecs[4] = '{8'h0F, 8'd200, 1'b0, 8'h00, 0};
    vecs[5] = '{8'hF0, 8'd128, 1'b1, 8'hF0, 128};

    // 1: reset state, idle hold.
    rst = 1'b1; leds_in = 8'h00; brightness = 8'd255; enable = 1'b1;
    cyc(3);
    rst = 1'b0;
    check("rst_leds_out", leds_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    bad = 0;
    for (int c = 0; c < 500; c++) begin
      cyc(1);
      if (leds_out != 8'h00 || busy != 1'b0) bad++;
    end
    check("idle_hold_bad_cycles", bad, 0);

    // 2: full 0->255 ramp on channel 0; level k after 10k cycles.
    do_reset(8'h01, 8'd255);
    #0;
    check("ramp_busy_start", busy, 1'b1);
    cyc(9);
    check("ramp_lvl_c9", dut.level_q[0], 8'd0);
    cyc(1);
    check("ramp_lvl_c10", dut.level_q[0], 8'd1);
    cyc(9);
    check("ramp_lvl_c19", dut.level_q[0], 8'd1);
    cyc(1);
    check("ramp_lvl_c20", dut.level_q[0], 8'd2);
    cyc(2529);
    check("ramp_lvl_c2549", dut.level_q[0], 8'd254);
    check("ramp_busy_c2549", busy, 1'b1);
    cyc(1);
    check("ramp_lvl_c2550", dut.level_q[0], 8'd255);
    check("ramp_busy_c2550", busy, 1'b0);
    cyc(1);
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      cyc(1);
      if (leds_out != 8'h01) bad++;
    end
    check("full_on_bad_cycles", bad, 0);

    // Table: settle each pattern, then check busy and per-channel duty.
    for (int v = 0; v < 6; v++) begin
      leds_in = vecs[v].leds; brightness = vecs[v].bright; enable = vecs[v].en;
      cyc(2600);
      check($sformatf("vec%0d_busy", v), busy, 1'b0);
      measure();
      for (int b = 0; b < 8; b++)
        check($sformatf("vec%0d_duty_ch%0d", v, b), hi_cnt[b],
              vecs[v].mask[b] ? vecs[v].hi : 0);
      if (v == 0) check("vec0_phase_ch0_ch7", phase_diff, 0);
    end

    // 4: drop the request at level 100; walk back down one per tick.
    do_reset(8'h01, 8'd255);
    cyc(1000);
    check("down_lvl_start", dut.level_q[0], 8'd100);
    leds_in = 8'h00;
    cyc(5);
    check("down_no_jump", dut.level_q[0], 8'd100);
    cyc(5);
    check("down_lvl_99", dut.level_q[0], 8'd99);
    cyc(10);
    check("down_lvl_98", dut.level_q[0], 8'd98);
    cyc(979);
    check("down_lvl_1", dut.level_q[0], 8'd1);
    check("down_busy_1", busy, 1'b1);
    cyc(1);
    check("down_lvl_0", dut.level_q[0], 8'd0);
    check("down_busy_0", busy, 1'b0);

    // 5: enable held low 100 cycles after reset shifts PWM phase so the
    // channel is lit when enable drops at level 200.
    do_reset(8'h01, 8'd255);
    enable = 1'b0;
    cyc(100);
    enable = 1'b1;
    cyc(2000);
    check("en_lvl_200", dut.level_q[0], 8'd200);
    check("en_lit_before_drop", leds_out, 8'h01);
    enable = 1'b0;
    #0;
    check("en_busy_low", busy, 1'b0);
    cyc(1);
    check("en_drop_leds_out", leds_out, 8'h00);
    check("en_drop_lvl", dut.level_q[0], 8'd0);
    enable = 1'b1;
    cyc(9);
    check("reen_lvl_c9", dut.level_q[0], 8'd0);
    check("reen_busy", busy, 1'b1);
    cyc(1);
    check("reen_lvl_c10", dut.level_q[0], 8'd1);

    // 6: reset at level 150 mid-ramp.
    do_reset(8'h01, 8'd255);
    cyc(1505);
    check("rst_mid_lvl_150", dut.level_q[0], 8'd150);
    rst = 1'b1; leds_in = 8'h00;
    cyc(1);
    check("rst_mid_leds_out", leds_out, 8'h00);
    check("rst_mid_lvl", dut.level_q[0], 8'd0);
    check("rst_mid_busy", busy, 1'b0);
    rst = 1'b0; leds_in = 8'h01;
    cyc(9);
    check("rst_mid_lvl_c9", dut.level_q[0], 8'd0);
    cyc(1);
    check("rst_mid_lvl_c10", dut.level_q[0], 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
